// File: rtl/ag6502_via.sv
// ag6502_via: bus-responder I/O and timer peripheral (reduced 6522 subset).
// Ports:
//   phi_0           system clock; all state updates on its rising edge
//   rst             asynchronous active-low reset
//   ab, read, db_out  CPU address, direction (1 = read) and write data
//   db_in, db_sel   registered read data and "this block drove db_in" flag
//   irq             active-low interrupt request
//   pa_*/pb_*       port pin inputs, output registers, per-bit output enables
//   ca1             asynchronous edge input
module ag6502_via #(
    parameter logic [15:0] BASE_ADDR = 16'hD000
) (
    input  logic        phi_0,
    input  logic        rst,
    input  logic [15:0] ab,
    input  logic        read,
    input  logic [7:0]  db_out,
    output logic [7:0]  db_in,
    output logic        db_sel,
    output logic        irq,
    input  logic [7:0]  pa_in,
    input  logic [7:0]  pb_in,
    output logic [7:0]  pa_out,
    output logic [7:0]  pb_out,
    output logic [7:0]  pa_oe,
    output logic [7:0]  pb_oe,
    input  logic        ca1
);
    logic [7:0]  orb_q, ora_q, ddrb_q, ddra_q, latch_lo_q, latch_hi_q, acr_q, pcr_q, db_in_q;
    logic [7:0]  orb_d, ora_d, ddrb_d, ddra_d, latch_lo_d, latch_hi_d, acr_d, pcr_d, db_in_d;
    logic [15:0] counter_q, counter_d;
    logic        armed_q, ifr6_q, ifr1_q, ier6_q, ier1_q, db_sel_q;
    logic        armed_d, ifr6_d, ifr1_d, ier6_d, ier1_d, db_sel_d;
    logic        ca1_s1_q, ca1_s2_q, ca1_prev_q;
    logic        sel, wr, rd, irq_any, set6, set1, clr6, clr1;
    logic [3:0]  idx;
    logic [7:0]  rd_data;

    assign sel     = (ab[15:4] == BASE_ADDR[15:4]);
    assign idx     = ab[3:0];
    assign wr      = sel & ~read;
    assign rd      = sel & read;
    assign irq_any = (ifr6_q & ier6_q) | (ifr1_q & ier1_q);
    assign irq     = ~irq_any;

    assign db_in  = db_in_q;
    assign db_sel = db_sel_q;
    assign pa_out = ora_q;
    assign pb_out = orb_q;
    assign pa_oe  = ddra_q;
    assign pb_oe  = ddrb_q;

    // Edge detect on the synchronized CA1; ca1_prev_q is the detector stage.
    assign set1 = pcr_q[0] ? (ca1_s2_q & ~ca1_prev_q) : (~ca1_s2_q & ca1_prev_q);
    assign set6 = (counter_q == 16'h0000) & armed_q;

    always_comb begin
        rd_data = 8'h00;
        case (idx)
            4'h0: rd_data = (orb_q & ddrb_q) | (pb_in & ~ddrb_q);
            4'h1: rd_data = (ora_q & ddra_q) | (pa_in & ~ddra_q);
            4'h2: rd_data = ddrb_q;
            4'h3: rd_data = ddra_q;
            4'h4: rd_data = counter_q[7:0];
            4'h5: rd_data = counter_q[15:8];
            4'h6: rd_data = latch_lo_q;
            4'h7: rd_data = latch_hi_q;
            4'hB: rd_data = acr_q;
            4'hC: rd_data = pcr_q;
            4'hD: rd_data = {irq_any, ifr6_q, 4'b0000, ifr1_q, 1'b0};
            4'hE: rd_data = {1'b1, ier6_q, 4'b0000, ier1_q, 1'b0};
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        orb_d      = orb_q;
        ora_d      = ora_q;
        ddrb_d     = ddrb_q;
        ddra_d     = ddra_q;
        latch_lo_d = latch_lo_q;
        latch_hi_d = latch_hi_q;
        acr_d      = acr_q;
        pcr_d      = pcr_q;
        ier6_d     = ier6_q;
        ier1_d     = ier1_q;
        armed_d    = armed_q;
        clr6       = 1'b0;
        clr1       = 1'b0;
        db_in_d    = db_in_q;
        db_sel_d   = 1'b0;
        counter_d  = counter_q - 16'd1;

        // Underflow: reload in free-run, otherwise let it wrap and disarm.
        if (set6) begin
            if (acr_q[6]) counter_d = {latch_hi_q, latch_lo_q};
            else          armed_d   = 1'b0;
        end

        if (wr) begin
            case (idx)
                4'h0: orb_d  = db_out;
                4'h1: begin ora_d = db_out; clr1 = 1'b1; end
                4'h2: ddrb_d = db_out;
                4'h3: ddra_d = db_out;
                4'h4: latch_lo_d = db_out;
                4'h5: begin
                    // Load overrides both decrement and free-run reload.
                    latch_hi_d = db_out;
                    counter_d  = {db_out, latch_lo_q};
                    clr6       = 1'b1;
                    armed_d    = 1'b1;
                end
                4'h6: latch_lo_d = db_out;
                4'h7: begin latch_hi_d = db_out; clr6 = 1'b1; end
                4'hB: acr_d = db_out;
                4'hC: pcr_d = db_out;
                4'hD: begin clr6 = db_out[6]; clr1 = db_out[1]; end
                4'hE: begin
                    if (db_out[7]) begin
                        ier6_d = ier6_q | db_out[6];
                        ier1_d = ier1_q | db_out[1];
                    end else begin
                        ier6_d = ier6_q & ~db_out[6];
                        ier1_d = ier1_q & ~db_out[1];
                    end
                end
                default: ;
            endcase
        end

        if (rd) begin
            db_in_d  = rd_data;
            db_sel_d = 1'b1;
            if (idx == 4'h1) clr1 = 1'b1;
            if (idx == 4'h4) clr6 = 1'b1;
        end
    end

    // Set has priority over any clear landing on the same edge.
    assign ifr6_d = set6 | (ifr6_q & ~clr6);
    assign ifr1_d = set1 | (ifr1_q & ~clr1);

    always_ff @(posedge phi_0 or negedge rst) begin
        if (!rst) begin
            orb_q <= '0; ora_q <= '0; ddrb_q <= '0; ddra_q <= '0;
            latch_lo_q <= '0; latch_hi_q <= '0; acr_q <= '0; pcr_q <= '0;
            counter_q <= '0; armed_q <= 1'b0;
            ifr6_q <= 1'b0; ifr1_q <= 1'b0; ier6_q <= 1'b0; ier1_q <= 1'b0;
            ca1_s1_q <= 1'b0; ca1_s2_q <= 1'b0; ca1_prev_q <= 1'b0;
            db_in_q <= '0; db_sel_q <= 1'b0;
        end else begin
            orb_q <= orb_d; ora_q <= ora_d; ddrb_q <= ddrb_d; ddra_q <= ddra_d;
            latch_lo_q <= latch_lo_d; latch_hi_q <= latch_hi_d;
            acr_q <= acr_d; pcr_q <= pcr_d;
            counter_q <= counter_d; armed_q <= armed_d;
            ifr6_q <= ifr6_d; ifr1_q <= ifr1_d; ier6_q <= ier6_d; ier1_q <= ier1_d;
            ca1_s1_q <= ca1; ca1_s2_q <= ca1_s1_q; ca1_prev_q <= ca1_s2_q;
            db_in_q <= db_in_d; db_sel_q <= db_sel_d;
        end
    end
endmodule

// File: tb/tb_ag6502_via.sv
// Directed bench for ag6502_via: table of register accesses plus hand-written
// timer and CA1 sequences. Inputs change on the falling edge; outputs are
// sampled 1 time unit after the rising edge.
module tb_ag6502_via;
    logic        phi_0 = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ab = 16'h0000;
    logic        read = 1'b1;
    logic [7:0]  db_out = 8'h00;
    logic [7:0]  db_in;
    logic        db_sel, irq;
    logic [7:0]  pa_in = 8'h00, pb_in = 8'h00;
    logic [7:0]  pa_out, pb_out, pa_oe, pb_oe;
    logic        ca1 = 1'b0;

    int tests = 0;
    int fails = 0;

    ag6502_via #(.BASE_ADDR(16'hD000)) dut (
        .phi_0(phi_0), .rst(rst), .ab(ab), .read(read), .db_out(db_out),
        .db_in(db_in), .db_sel(db_sel), .irq(irq),
        .pa_in(pa_in), .pb_in(pb_in), .pa_out(pa_out), .pb_out(pb_out),
        .pa_oe(pa_oe), .pb_oe(pb_oe), .ca1(ca1)
    );

    always #5 phi_0 = ~phi_0;

    typedef struct {
        logic [3:0] idx;
        logic       rd;
        logic [7:0] wd;
        logic [7:0] pbi;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Called at a falling edge; performs one bus cycle and returns at the next
    // falling edge with the bus idle (outputs unchanged since the rising edge).
    task automatic bus(input logic [3:0] idx, input logic rd, input logic [7:0] wd);
        ab = {12'hD00, idx}; read = rd; db_out = wd;
        @(posedge phi_0); #1;
        ab = 16'h0000; read = 1'b1;
        @(negedge phi_0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge phi_0); #1;
            @(negedge phi_0);
        end
    endtask

    initial begin
        // Post-reset reads of every offset: access k lands on edge k+1, so the
        // free-running counter (from 0000) reads FFFC at offset 4, FFFB at 5.
        for (int i = 0; i < 16; i++) tbl[i] = '{i[3:0], 1'b1, 8'h00, 8'h00, 1'b1, 8'h00};
        tbl[4].exp  = 8'hFC;
        tbl[5].exp  = 8'hFF;
        tbl[14].exp = 8'h80;
        tbl[16] = '{4'h2, 1'b0, 8'hF0, 8'h3C, 1'b0, 8'h00};
        tbl[17] = '{4'h0, 1'b0, 8'hA5, 8'h3C, 1'b0, 8'h00};
        tbl[18] = '{4'h0, 1'b1, 8'h00, 8'h3C, 1'b1, 8'hAC};

        repeat (3) @(negedge phi_0);
        check("rst_db_in", db_in, 8'h00);
        check("rst_db_sel", {7'd0, db_sel}, 8'h00);
        check("rst_irq", {7'd0, irq}, 8'h01);
        check("rst_pa_oe", pa_oe, 8'h00);
        check("rst_pb_oe", pb_oe, 8'h00);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            pb_in = tbl[i].pbi;
            bus(tbl[i].idx, tbl[i].rd, tbl[i].wd);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_db_in", i), db_in, tbl[i].exp);
                check($sformatf("vec%0d_db_sel", i), {7'd0, db_sel}, 8'h01);
            end
        end
        check("reset_irq", {7'd0, irq}, 8'h01);
        check("pb_out", pb_out, 8'hA5);
        check("pb_oe", pb_oe, 8'hF0);
        idle(1);
        check("db_sel_idle", {7'd0, db_sel}, 8'h00);
        check("db_in_hold", db_in, 8'hAC);

        // One-shot: T1C-H write at E with counter = 5 -> flag at E+6.
        bus(4'hE, 1'b0, 8'hC0);
        bus(4'h4, 1'b0, 8'h05);
        bus(4'h5, 1'b0, 8'h00);
        idle(5);
        check("os_irq_e5", {7'd0, irq}, 8'h01);
        idle(1);
        check("os_irq_e6", {7'd0, irq}, 8'h00);
        bus(4'h4, 1'b1, 8'h00);
        check("os_t1cl_rd", db_in, 8'hFF);
        check("os_irq_clr", {7'd0, irq}, 8'h01);
        idle(10);
        check("os_no_refire", {7'd0, irq}, 8'h01);

        // Free-run with latch 0003: period 4.
        bus(4'hB, 1'b0, 8'h40);
        bus(4'h4, 1'b0, 8'h03);
        bus(4'h5, 1'b0, 8'h00);            // E
        idle(3);
        check("fr_irq_e3", {7'd0, irq}, 8'h01);
        idle(1);
        check("fr_irq_e4", {7'd0, irq}, 8'h00);
        bus(4'hD, 1'b0, 8'h40);            // E+5 clear
        check("fr_clr_e5", {7'd0, irq}, 8'h01);
        idle(2);
        check("fr_irq_e7", {7'd0, irq}, 8'h01);
        idle(1);
        check("fr_irq_e8", {7'd0, irq}, 8'h00);
        bus(4'hD, 1'b0, 8'h40);            // E+9 clear
        check("fr_clr_e9", {7'd0, irq}, 8'h01);
        idle(2);
        bus(4'hD, 1'b0, 8'h40);            // E+12 clear collides with underflow
        check("fr_set_wins", {7'd0, irq}, 8'h00);
        bus(4'hD, 1'b1, 8'h00);
        check("fr_ifr_rd", db_in, 8'hC0);

        // Back to one-shot, let it expire, then clear flag and disable.
        bus(4'hB, 1'b0, 8'h00);
        idle(6);
        bus(4'hD, 1'b0, 8'h7F);
        bus(4'hE, 1'b0, 8'h40);
        check("ier_clr_irq", {7'd0, irq}, 8'h01);
        bus(4'hE, 1'b1, 8'h00);
        check("ier_rd", db_in, 8'h80);

        // CA1 rising edge -> IFR1 on the third edge after the transition.
        bus(4'hC, 1'b0, 8'h01);
        bus(4'hE, 1'b0, 8'h82);
        ca1 = 1'b1;
        idle(2);
        check("ca1_edge2", {7'd0, irq}, 8'h01);
        idle(1);
        check("ca1_edge3", {7'd0, irq}, 8'h00);
        bus(4'hD, 1'b1, 8'h00);
        check("ca1_ifr", db_in, 8'h82);
        bus(4'h1, 1'b1, 8'h00);
        check("ca1_ira", db_in, 8'h00);
        check("ca1_clr", {7'd0, irq}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
